fsm_experiment_multi: RTL and testbench
=======================================

Name: fsm_experiment_multi

Overview:
- Parametrised next-generation experiment sequencer for the synchronization block.
- Sequence: start → frame-grabber opto → programmable open delay → NUM_DET detonation pulses, each with its own offset → wire-triggered output trigger → detector handshake with timeout → finished.
- Sits between the input conditioning and the output drivers. Timing values are runtime configuration ports, latched at start.
- Adds over the previous generation: multi-channel detonation, abort, timeout status and a shot counter.

Parameters:
- CNT_W, 32: width of all timing counters and config values.
- NUM_DET, 4: number of detonation output channels (1..8).
- SYNC_STAGES, 2: synchroniser depth for asynchronous inputs (minimum 2).

Ports:
- clock  in  1  system clock.
- reset_signal  in  1  asynchronous, active-low reset.
- start_signal  in  1  async; rising edge arms a shot; must be low to rearm.
- abort_signal  in  1  async; rising edge aborts the shot.
- fg_signal  in  1  async; frame-grabber opto.
- wire_signal  in  1  async; wire-break trigger.
- detector_ready  in  1  async; high = detector idle/ready.
- cfg_fg_open_delay  in  CNT_W  frame-grabber open delay, in cycles.
- cfg_det_len  in  CNT_W  detonation pulse length, common to all channels.
- cfg_det_offset  in  NUM_DET*CNT_W  per-channel pulse offset; channel i occupies bits [i*CNT_W +: CNT_W].
- cfg_det_enable  in  NUM_DET  per-channel enable.
- cfg_trigger_len  in  CNT_W  output trigger length.
- cfg_detector_timeout  in  CNT_W  detector handshake timeout.
- detonation_signal  out  NUM_DET  registered detonation pulses.
- output_trigger  out  1  registered trigger.
- scenario_state  out  8  {4'b0, state}.
- timeout_flag  out  1  last shot ended by detector timeout.
- busy  out  1  state != IDLE.
- shot_count  out  16  completed shots, wraps 0xFFFF→0.

Behaviour:
- Reset (async, active-low):
  - state=IDLE, counter=0, all outputs 0, shot_count=0, synchroniser flops 0.
- Input conditioning:
  - All async inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised value versus its previous value. Level tests also use synchronised values.
- Config latch:
  - All cfg_* values are captured in the cycle the start edge is accepted in IDLE.
  - Config changes mid-shot have no effect.
- State encoding: IDLE=0, FG_WAIT_OPTO=1, FG_WAIT_OPEN=2, DETONATE=3, WIRE_TRIGGER=4, TRIGGER_PROLONG=5, DETECTOR_BUSY=6, DETECTOR_WAIT=7, DETECTOR_FINISHED=8, ABORTED=9.
- State transitions:
  - IDLE → FG_WAIT_OPTO on start rising edge. Start edges in any other state are ignored.
  - FG_WAIT_OPTO → FG_WAIT_OPEN on fg rising edge; counter=0.
  - FG_WAIT_OPEN: stays exactly D+1 cycles, where D is the latched delay, then → DETONATE with counter=0.
  - DETONATE, channel i enabled, state entered at cycle T: detonation_signal[i]=1 during cycles T+1+off_i .. T+off_i+len. That is exactly len cycles; len=0 gives no pulse.
  - DETONATE exit: when counter reaches E = max over enabled channels of (off_i+len). Compare at CNT_W+1 bits so no overflow occurs. If no channel is enabled, E=0 and DETONATE lasts 1 cycle. All detonation outputs are 0 on exit.
  - WIRE_TRIGGER: on wire rising edge → TRIGGER_PROLONG, and output_trigger=1 from the next cycle.
  - TRIGGER_PROLONG: output_trigger stays high for max(trigger_len,1) cycles total, then drops → DETECTOR_BUSY with counter=0.
  - DETECTOR_BUSY: detector_ready low → DETECTOR_WAIT, counter=0. If counter reaches timeout first → DETECTOR_FINISHED with timeout_flag=1.
  - DETECTOR_WAIT: detector_ready high → DETECTOR_FINISHED with timeout_flag=0. If counter reaches timeout first → DETECTOR_FINISHED with timeout_flag=1.
  - DETECTOR_FINISHED: shot_count increments once on entry. Return to IDLE when synchronised start is low.
- timeout_flag:
  - Holds its value until the next accepted start, which clears it.
- Abort:
  - Abort rising edge in any state except IDLE → ABORTED.
  - All detonation/trigger outputs are 0 from the next cycle; shot_count is unchanged.
  - Abort has priority over every other transition in the same cycle.
  - ABORTED → IDLE when start is low.
- Unused encodings (10-15) → IDLE.

Test Plan:
- Nominal, delay=10, len=5, offsets {0,3,6,9} all enabled, trigger_len=4, detector drops then rises → pulses on each channel 5 cycles long, staggered by 3; trigger high 4 cycles; shot_count=1; timeout_flag=0.
- cfg_det_enable=0 → DETONATE lasts 1 cycle; no pulses; sequence completes normally.
- detector_ready held high, timeout=20 → DETECTOR_FINISHED after 20 cycles in DETECTOR_BUSY; timeout_flag=1; next start clears it.
- Abort pulse midway through a detonation pulse → all outputs 0 next cycle; state 9; IDLE after start is released; shot_count unchanged.
- reset_signal asserted low mid-TRIGGER_PROLONG → output_trigger=0 immediately (asynchronous); state 0 and busy=0 until reset is released.
- Start held high through DETECTOR_FINISHED → stays in state 8; returns to IDLE only after start falls; second start rising edge runs a second shot, shot_count=2.

Source files
------------

// File: rtl/fsm_experiment_multi.sv
`default_nettype none
// ============================================================================
// Module   : fsm_experiment_multi
// Purpose  : Experiment sequencer for the synchronisation block. Walks a shot
//            through start -> frame-grabber opto -> open delay -> multi-channel
//            detonation -> wire-triggered output trigger -> detector handshake
//            (with timeout) -> finished. An abort edge stops any running shot.
// Ports    : clock, reset_signal (async, active-low)
//            start/abort/fg/wire/detector_ready : asynchronous inputs
//            cfg_*              : timing config, captured when a shot starts
//            detonation_signal  : registered per-channel detonation pulses
//            output_trigger     : registered output trigger
//            scenario_state     : {4'b0, state}
//            timeout_flag       : last shot ended by detector timeout
//            busy               : sequencer not idle
//            shot_count         : completed shots (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fsm_experiment_multi #(
  parameter int CNT_W       = 32,
  parameter int NUM_DET     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_signal,
  input  logic                     start_signal,
  input  logic                     abort_signal,
  input  logic                     fg_signal,
  input  logic                     wire_signal,
  input  logic                     detector_ready,
  input  logic [CNT_W-1:0]         cfg_fg_open_delay,
  input  logic [CNT_W-1:0]         cfg_det_len,
  input  logic [NUM_DET*CNT_W-1:0] cfg_det_offset,
  input  logic [NUM_DET-1:0]       cfg_det_enable,
  input  logic [CNT_W-1:0]         cfg_trigger_len,
  input  logic [CNT_W-1:0]         cfg_detector_timeout,
  output logic [NUM_DET-1:0]       detonation_signal,
  output logic                     output_trigger,
  output logic [7:0]               scenario_state,
  output logic                     timeout_flag,
  output logic                     busy,
  output logic [15:0]              shot_count
);

  // One extra bit so offset+length sums never wrap.
  localparam int             c_EW      = CNT_W + 1;
  localparam logic [c_EW-1:0] c_CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  localparam int c_IDX_START = 0;
  localparam int c_IDX_ABORT = 1;
  localparam int c_IDX_FG    = 2;
  localparam int c_IDX_WIRE  = 3;
  localparam int c_IDX_READY = 4;

  typedef enum logic [3:0] {
    IDLE              = 4'd0,
    FG_WAIT_OPTO      = 4'd1,
    FG_WAIT_OPEN      = 4'd2,
    DETONATE          = 4'd3,
    WIRE_TRIGGER      = 4'd4,
    TRIGGER_PROLONG   = 4'd5,
    DETECTOR_BUSY     = 4'd6,
    DETECTOR_WAIT     = 4'd7,
    DETECTOR_FINISHED = 4'd8,
    ABORTED           = 4'd9
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers and rising-edge detection
  // --------------------------------------------------------------------------
  logic [4:0] w_async;
  logic [4:0] r_sync [SYNC_STAGES];
  logic [4:0] r_sync_q;
  logic [4:0] w_sync;
  logic [4:0] w_rise;

  assign w_async = {detector_ready, wire_signal, fg_signal, abort_signal, start_signal};

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_sync_q <= '0;
    end else begin
      r_sync[0] <= w_async;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_sync_q <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_sync_q;

  // --------------------------------------------------------------------------
  // State, counter and output registers
  // --------------------------------------------------------------------------
  state_t              r_state, w_state_nxt;
  logic [c_EW-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_DET-1:0]  r_det, w_det_nxt;
  logic                r_trig, w_trig_nxt;
  logic                r_tflag, w_tflag_nxt;
  logic [15:0]         r_shots, w_shots_nxt;

  // Latched configuration
  logic [CNT_W-1:0]         r_fg_delay;
  logic [CNT_W-1:0]         r_det_len;
  logic [NUM_DET*CNT_W-1:0] r_det_off;
  logic [NUM_DET-1:0]       r_det_en;
  logic [CNT_W-1:0]         r_trig_len;
  logic [CNT_W-1:0]         r_timeout;

  logic w_accept;
  assign w_accept = (r_state == IDLE) && w_rise[c_IDX_START];

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_fg_delay <= '0;
      r_det_len  <= '0;
      r_det_off  <= '0;
      r_det_en   <= '0;
      r_trig_len <= '0;
      r_timeout  <= '0;
    end else if (w_accept) begin
      r_fg_delay <= cfg_fg_open_delay;
      r_det_len  <= cfg_det_len;
      r_det_off  <= cfg_det_offset;
      r_det_en   <= cfg_det_enable;
      r_trig_len <= cfg_trigger_len;
      r_timeout  <= cfg_detector_timeout;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel pulse windows: channel i is driven for counter values
  // off_i <= cnt < off_i+len, which appear one cycle later on the output.
  // --------------------------------------------------------------------------
  logic [c_EW-1:0]    w_ch_end [NUM_DET];
  logic [NUM_DET-1:0] w_det_on;
  logic [c_EW-1:0]    w_det_end;
  logic [c_EW-1:0]    w_trig_last;

  for (genvar gi = 0; gi < NUM_DET; gi++) begin : g_ch
    assign w_ch_end[gi] = {1'b0, r_det_off[gi*CNT_W +: CNT_W]} + {1'b0, r_det_len};
    assign w_det_on[gi] = r_det_en[gi]
                        && (r_cnt >= {1'b0, r_det_off[gi*CNT_W +: CNT_W]})
                        && (r_cnt < w_ch_end[gi]);
  end

  always_comb begin
    w_det_end = '0;
    for (int i = 0; i < NUM_DET; i++) begin
      if (r_det_en[i] && (w_ch_end[i] > w_det_end)) w_det_end = w_ch_end[i];
    end
  end

  // Trigger is high for max(len,1) cycles: counter values 0 .. max(len,1)-1.
  assign w_trig_last = (r_trig_len == '0) ? '0 : ({1'b0, r_trig_len} - c_CNT_ONE);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_det_nxt   = '0;
    w_trig_nxt  = 1'b0;
    w_tflag_nxt = r_tflag;
    w_shots_nxt = r_shots;

    case (r_state)
      IDLE: begin
        if (w_rise[c_IDX_START]) begin
          w_state_nxt = FG_WAIT_OPTO;
          w_cnt_nxt   = '0;
          w_tflag_nxt = 1'b0;
        end
      end
      FG_WAIT_OPTO: begin
        if (w_rise[c_IDX_FG]) begin
          w_state_nxt = FG_WAIT_OPEN;
          w_cnt_nxt   = '0;
        end
      end
      FG_WAIT_OPEN: begin
        if (r_cnt >= {1'b0, r_fg_delay}) begin
          w_state_nxt = DETONATE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      DETONATE: begin
        if (r_cnt >= w_det_end) begin
          w_state_nxt = WIRE_TRIGGER;
          w_cnt_nxt   = '0;
        end else begin
          w_det_nxt = w_det_on;
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      WIRE_TRIGGER: begin
        if (w_rise[c_IDX_WIRE]) begin
          w_state_nxt = TRIGGER_PROLONG;
          w_cnt_nxt   = '0;
          w_trig_nxt  = 1'b1;
        end
      end
      TRIGGER_PROLONG: begin
        if (r_cnt >= w_trig_last) begin
          w_state_nxt = DETECTOR_BUSY;
          w_cnt_nxt   = '0;
        end else begin
          w_trig_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + c_CNT_ONE;
        end
      end
      DETECTOR_BUSY: begin
        if (!w_sync[c_IDX_READY]) begin
          w_state_nxt = DETECTOR_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= {1'b0, r_timeout}) begin
          w_state_nxt = DETECTOR_FINISHED;
          w_tflag_nxt = 1'b1;
          w_shots_nxt = r_shots + 16'd1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      DETECTOR_WAIT: begin
        if (w_sync[c_IDX_READY]) begin
          w_state_nxt = DETECTOR_FINISHED;
          w_tflag_nxt = 1'b0;
          w_shots_nxt = r_shots + 16'd1;
        end else if (r_cnt >= {1'b0, r_timeout}) begin
          w_state_nxt = DETECTOR_FINISHED;
          w_tflag_nxt = 1'b1;
          w_shots_nxt = r_shots + 16'd1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      DETECTOR_FINISHED: begin
        if (!w_sync[c_IDX_START]) w_state_nxt = IDLE;
      end
      ABORTED: begin
        if (!w_sync[c_IDX_START]) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Abort overrides whatever the state logic decided this cycle.
    if ((r_state != IDLE) && w_rise[c_IDX_ABORT]) begin
      w_state_nxt = ABORTED;
      w_cnt_nxt   = '0;
      w_det_nxt   = '0;
      w_trig_nxt  = 1'b0;
      w_tflag_nxt = r_tflag;
      w_shots_nxt = r_shots;
    end
  end

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_det   <= '0;
      r_trig  <= 1'b0;
      r_tflag <= 1'b0;
      r_shots <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_det   <= w_det_nxt;
      r_trig  <= w_trig_nxt;
      r_tflag <= w_tflag_nxt;
      r_shots <= w_shots_nxt;
    end
  end

  assign detonation_signal = r_det;
  assign output_trigger    = r_trig;
  assign scenario_state    = {4'b0000, r_state};
  assign timeout_flag      = r_tflag;
  assign busy              = (r_state != IDLE);
  assign shot_count        = r_shots;

endmodule
`default_nettype wire

// File: tb/tb_fsm_experiment_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fsm_experiment_multi
// Purpose  : Self-checking bench for fsm_experiment_multi. Expected per-cycle
//            detonation vectors, trigger width and end-of-shot status are
//            queued when a shot is launched and popped by a monitor as the
//            DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_experiment_multi;

  localparam int CNT_W       = 32;
  localparam int NUM_DET     = 4;
  localparam int SYNC_STAGES = 2;

  logic                     clock = 1'b0;
  logic                     reset_signal;
  logic                     start_signal;
  logic                     abort_signal;
  logic                     fg_signal;
  logic                     wire_signal;
  logic                     detector_ready;
  logic [CNT_W-1:0]         cfg_fg_open_delay;
  logic [CNT_W-1:0]         cfg_det_len;
  logic [NUM_DET*CNT_W-1:0] cfg_det_offset;
  logic [NUM_DET-1:0]       cfg_det_enable;
  logic [CNT_W-1:0]         cfg_trigger_len;
  logic [CNT_W-1:0]         cfg_detector_timeout;
  logic [NUM_DET-1:0]       detonation_signal;
  logic                     output_trigger;
  logic [7:0]               scenario_state;
  logic                     timeout_flag;
  logic                     busy;
  logic [15:0]              shot_count;

  fsm_experiment_multi #(
    .CNT_W       (CNT_W),
    .NUM_DET     (NUM_DET),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dut (
    .clock                (clock),
    .reset_signal         (reset_signal),
    .start_signal         (start_signal),
    .abort_signal         (abort_signal),
    .fg_signal            (fg_signal),
    .wire_signal          (wire_signal),
    .detector_ready       (detector_ready),
    .cfg_fg_open_delay    (cfg_fg_open_delay),
    .cfg_det_len          (cfg_det_len),
    .cfg_det_offset       (cfg_det_offset),
    .cfg_det_enable       (cfg_det_enable),
    .cfg_trigger_len      (cfg_trigger_len),
    .cfg_detector_timeout (cfg_detector_timeout),
    .detonation_signal    (detonation_signal),
    .output_trigger       (output_trigger),
    .scenario_state       (scenario_state),
    .timeout_flag         (timeout_flag),
    .busy                 (busy),
    .shot_count           (shot_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks  = 0;
  int       n_fail    = 0;
  int       exp_shots = 0;
  bit       sb_en     = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.val);
    end
  endtask

  // Reference model for one complete shot using the current cfg values.
  task automatic push_shot(input bit exp_tflag);
    int          e;
    int          off;
    int          len;
    logic [31:0] v;
    len = int'(cfg_det_len);
    e   = 0;
    for (int i = 0; i < NUM_DET; i++) begin
      off = int'(cfg_det_offset[i*CNT_W +: CNT_W]);
      if (cfg_det_enable[i] && (off + len > e)) e = off + len;
    end
    for (int k = 0; k <= e; k++) begin
      v = '0;
      for (int i = 0; i < NUM_DET; i++) begin
        off = int'(cfg_det_offset[i*CNT_W +: CNT_W]);
        if (cfg_det_enable[i] && (k >= off + 1) && (k <= off + len)) v[i] = 1'b1;
      end
      sb_push("det_cycle", v);
    end
    sb_push("det_exit", 32'd0);
    sb_push("trig_width", (cfg_trigger_len == 0) ? 32'd1 : cfg_trigger_len);
    sb_push("timeout_flag", {31'd0, exp_tflag});
    exp_shots = (exp_shots + 1) & 16'hFFFF;
    sb_push("shot_count", 32'(exp_shots));
  endtask

  // Monitor: produces observations in the same order the model queues them.
  logic [3:0] mon_prev  = 4'd0;
  int         mon_trigw = 0;

  always @(negedge clock) begin
    if (sb_en) begin
      if (scenario_state == 8'd3)      sb_pop_check(32'(detonation_signal));
      else if (mon_prev == 4'd3)       sb_pop_check(32'(detonation_signal));
      if (output_trigger) begin
        mon_trigw++;
      end else if (mon_trigw != 0) begin
        sb_pop_check(32'(mon_trigw));
        mon_trigw = 0;
      end
      if ((scenario_state == 8'd8) && (mon_prev != 4'd8)) begin
        sb_pop_check(32'(timeout_flag));
        sb_pop_check(32'(shot_count));
      end
    end else begin
      mon_trigw = 0;
    end
    mon_prev = scenario_state[3:0];
  end

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while ((int'(scenario_state) != s) && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    if (int'(scenario_state) != s) check_val("wait_state", 32'(scenario_state), 32'(s));
  endtask

  task automatic count_dwell(input int s, input int budget, output int n);
    n = 0;
    while ((int'(scenario_state) == s) && (n < budget)) begin
      n++;
      @(negedge clock);
    end
  endtask

  // Drives one shot end to end; cfg is scrambled after acceptance to show
  // that only the values latched at start matter.
  task automatic run_shot(input bit hold_start, input bit drop_ready);
    int               n;
    logic [CNT_W-1:0] sv_delay, sv_len, sv_tlen, sv_to;
    sv_delay = cfg_fg_open_delay;
    sv_len   = cfg_det_len;
    sv_tlen  = cfg_trigger_len;
    sv_to    = cfg_detector_timeout;
    start_signal = 1'b1;
    wait_state(1, 20);
    if (!hold_start) start_signal = 1'b0;
    cfg_fg_open_delay    = sv_delay + 5;
    cfg_det_len          = sv_len + 2;
    cfg_trigger_len      = sv_tlen + 3;
    cfg_detector_timeout = sv_to + 9;
    fg_signal = 1'b1;
    wait_state(2, 20);
    fg_signal = 1'b0;
    count_dwell(2, 1000, n);
    check_val("open_dwell", 32'(n), sv_delay + 1);
    wait_state(4, 1000);
    wire_signal = 1'b1;
    wait_state(5, 20);
    wire_signal = 1'b0;
    wait_state(6, 1000);
    if (drop_ready) begin
      detector_ready = 1'b0;
      wait_state(7, 20);
      detector_ready = 1'b1;
      wait_state(8, 20);
    end else begin
      count_dwell(6, 1000, n);
      check_val("busy_timeout_dwell", 32'(n), sv_to + 1);
      wait_state(8, 5);
    end
    if (hold_start) begin
      repeat (5) @(negedge clock);
      check_val("hold_in_finished", 32'(scenario_state), 32'd8);
      start_signal = 1'b0;
    end
    wait_state(0, 20);
    cfg_fg_open_delay    = sv_delay;
    cfg_det_len          = sv_len;
    cfg_trigger_len      = sv_tlen;
    cfg_detector_timeout = sv_to;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_signal         = 1'b0;
    start_signal         = 1'b0;
    abort_signal         = 1'b0;
    fg_signal            = 1'b0;
    wire_signal          = 1'b0;
    detector_ready       = 1'b1;
    cfg_fg_open_delay    = 32'd10;
    cfg_det_len          = 32'd5;
    cfg_det_offset       = {32'd9, 32'd6, 32'd3, 32'd0};
    cfg_det_enable       = 4'hF;
    cfg_trigger_len      = 32'd4;
    cfg_detector_timeout = 32'd100;

    repeat (3) @(negedge clock);
    check_val("rst_state", 32'(scenario_state), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_det", 32'(detonation_signal), 32'd0);
    check_val("rst_trig", 32'(output_trigger), 32'd0);
    check_val("rst_shots", 32'(shot_count), 32'd0);
    check_val("rst_tflag", 32'(timeout_flag), 32'd0);
    reset_signal = 1'b1;
    repeat (3) @(negedge clock);

    // Nominal shot
    sb_en = 1'b1;
    push_shot(1'b0);
    run_shot(1'b0, 1'b1);
    check_val("t1_shots", 32'(shot_count), 32'd1);
    check_val("t1_busy_idle", 32'(busy), 32'd0);

    // No channel enabled: one-cycle DETONATE, no pulses
    cfg_det_enable = 4'h0;
    push_shot(1'b0);
    run_shot(1'b0, 1'b1);

    // Detector never drops: timeout path
    cfg_det_enable       = 4'hF;
    cfg_detector_timeout = 32'd20;
    push_shot(1'b1);
    run_shot(1'b0, 1'b0);
    check_val("t3_tflag_holds", 32'(timeout_flag), 32'd1);

    // Next start clears the flag; abort mid-detonation
    sb_en        = 1'b0;
    start_signal = 1'b1;
    wait_state(1, 20);
    check_val("t4_tflag_cleared", 32'(timeout_flag), 32'd0);
    fg_signal = 1'b1;
    wait_state(2, 20);
    fg_signal = 1'b0;
    wait_state(3, 100);
    repeat (4) @(negedge clock);
    check_val("t4_det_mid", 32'(detonation_signal), 32'h3);
    abort_signal = 1'b1;
    wait_state(9, 10);
    check_val("t4_abort_det", 32'(detonation_signal), 32'd0);
    check_val("t4_abort_trig", 32'(output_trigger), 32'd0);
    check_val("t4_abort_shots", 32'(shot_count), 32'(exp_shots));
    repeat (4) @(negedge clock);
    check_val("t4_abort_hold", 32'(scenario_state), 32'd9);
    start_signal = 1'b0;
    abort_signal = 1'b0;
    wait_state(0, 20);

    // Asynchronous reset during TRIGGER_PROLONG
    cfg_trigger_len = 32'd50;
    start_signal    = 1'b1;
    wait_state(1, 20);
    start_signal = 1'b0;
    fg_signal    = 1'b1;
    wait_state(2, 20);
    fg_signal = 1'b0;
    wait_state(4, 100);
    wire_signal = 1'b1;
    wait_state(5, 20);
    wire_signal = 1'b0;
    repeat (2) @(negedge clock);
    check_val("t5_trig_before", 32'(output_trigger), 32'd1);
    #1 reset_signal = 1'b0;
    #1;
    check_val("t5_trig_async", 32'(output_trigger), 32'd0);
    check_val("t5_state_async", 32'(scenario_state), 32'd0);
    check_val("t5_busy_async", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check_val("t5_state_held", 32'(scenario_state), 32'd0);
    check_val("t5_shots_rst", 32'(shot_count), 32'd0);
    exp_shots    = 0;
    reset_signal = 1'b1;
    repeat (3) @(negedge clock);

    // Start held through FINISHED, then a second shot
    cfg_trigger_len = 32'd4;
    sb_en = 1'b1;
    push_shot(1'b0);
    run_shot(1'b1, 1'b1);
    check_val("t6_shots_1", 32'(shot_count), 32'd1);
    push_shot(1'b0);
    run_shot(1'b0, 1'b1);
    check_val("t6_shots_2", 32'(shot_count), 32'd2);
    repeat (3) @(negedge clock);
    sb_en = 1'b0;

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
